// File: rtl/bias_fetch_ctrl_pkg.sv
// Shared constants and FSM state type for the bias BRAM fetch path.
package bias_fetch_ctrl_pkg;

  localparam int unsigned BIAS_ADDR_W     = 7;
  localparam int unsigned BIAS_DATA_W     = 32;
  localparam int unsigned BIAS_CNT_W      = 8;
  localparam int unsigned BIAS_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/bias_fetch_ctrl_if.sv
// Request, bias BRAM read port and bias stream of the fetch controller.
interface bias_fetch_ctrl_if
  import bias_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = BIAS_ADDR_W,
  parameter int unsigned DATA_W = BIAS_DATA_W,
  parameter int unsigned CNT_W  = BIAS_CNT_W
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              bias_bram_en;
  logic [ADDR_W-1:0] bias_bram_addr;
  logic [DATA_W-1:0] bias_bram_dout;
  logic              bias_bram_rd_vld;
  logic              bias_valid;
  logic [DATA_W-1:0] bias_data;
  logic              bias_last;
  logic              bias_ready;

  // Controller side
  modport master (
    input  start, base_addr, count, bias_bram_dout, bias_bram_rd_vld, bias_ready,
    output busy, done, bias_bram_en, bias_bram_addr, bias_valid, bias_data, bias_last
  );

  // Environment side (requester, BRAM wrapper, bias-add stage)
  modport slave (
    output start, base_addr, count, bias_bram_dout, bias_bram_rd_vld, bias_ready,
    input  busy, done, bias_bram_en, bias_bram_addr, bias_valid, bias_data, bias_last
  );

endinterface

// File: rtl/bias_fetch_ctrl_fifo.sv
// Small synchronous FIFO with a combinational head output.
module bias_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bias_fetch_ctrl.sv
// Walks a bias BRAM address range and streams the words out with a last marker.
module bias_fetch_ctrl
  import bias_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = BIAS_ADDR_W,
  parameter int unsigned DATA_W     = BIAS_DATA_W,
  parameter int unsigned CNT_W      = BIAS_CNT_W,
  parameter int unsigned FIFO_DEPTH = BIAS_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst,
  bias_fetch_ctrl_if.master bus
);

  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [CNT_W-1:0]  r_issued, w_issued_nxt;
  logic [CNT_W-1:0]  r_popped, w_popped_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_inflight;
  logic              w_en;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_head;
  logic [OCC_W:0]    w_need;
  logic [OCC_W:0]    w_room;
  logic              w_credit;
  logic              w_issue_ok;
  logic              w_is_last;

  bias_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (OCC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.bias_bram_dout),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ),
    .o_head  (w_head)
  );

  // Stale read-valids while idle are dropped.
  assign w_push     = bus.bias_bram_rd_vld & (r_state != ST_IDLE);
  assign w_pop      = ~w_empty & bus.bias_ready;
  assign w_is_last  = (r_popped == r_count - CNT_W'(1));
  // A read issued now lands next cycle; it needs a slot even if nothing pops then.
  assign w_need     = (OCC_W+1)'(w_occ) + (OCC_W+1)'(r_inflight);
  assign w_room     = (OCC_W+1)'(FIFO_DEPTH) + (OCC_W+1)'(w_pop);
  assign w_credit   = (w_need < w_room);
  assign w_issue_ok = (r_issued < r_count) & w_credit;

  // The read enable is decided in its own cycle so the credit check can use this
  // cycle's pop; that is what lets two FIFO entries sustain one word per cycle.
  assign bus.bias_bram_en   = w_en;
  assign bus.bias_bram_addr = r_addr;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.bias_valid     = ~w_empty;
  assign bus.bias_data      = w_head;
  assign bus.bias_last      = ~w_empty & w_is_last;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      r_issued   <= w_issued_nxt;
      r_popped   <= w_popped_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_inflight <= w_en;
    end
  end

  // Next-state, read issue and completion
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_count_nxt  = r_count;
    w_issued_nxt = r_issued;
    w_popped_nxt = r_popped;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_en         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            w_state_nxt  = ST_FETCH;
            w_addr_nxt   = bus.base_addr;
            w_count_nxt  = bus.count;
            w_issued_nxt = '0;
            w_popped_nxt = '0;
            w_busy_nxt   = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (w_issue_ok) begin
          w_en         = 1'b1;
          w_addr_nxt   = r_addr + ADDR_W'(1);
          w_issued_nxt = r_issued + CNT_W'(1);
        end
        if (r_issued == r_count) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DRAIN;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if ((r_state != ST_IDLE) && w_pop) begin
      w_popped_nxt = r_popped + CNT_W'(1);
      if (w_is_last) begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Credit logic must never let a capture land in a full FIFO.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full && !w_pop)) else $error("bias_fifo overflow");
    end
  end

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Scoreboard bench for bias_fetch_ctrl with a 1-cycle-latency BRAM model.
module tb_bias_fetch_ctrl;
  import bias_fetch_ctrl_pkg::*;

  localparam int unsigned AW    = BIAS_ADDR_W;
  localparam int unsigned DW    = BIAS_DATA_W;
  localparam int unsigned CW    = BIAS_CNT_W;
  localparam int unsigned DEPTH = BIAS_FIFO_DEPTH;
  localparam int unsigned NADDR = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bias_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  bias_fetch_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // BRAM model: data and valid one cycle after en; inj_vld forces a stray valid.
  logic [DW-1:0] mem [NADDR];
  logic          bram_vld  = 1'b0;
  logic          inj_vld   = 1'b0;
  logic [DW-1:0] bram_dout = '0;
  always @(posedge clk) begin
    bram_vld  <= bus.bias_bram_en;
    bram_dout <= mem[bus.bias_bram_addr];
  end
  assign bus.bias_bram_rd_vld = bram_vld | inj_vld;
  assign bus.bias_bram_dout   = bram_dout;

  exp_t          exp_q[$];
  logic [AW-1:0] exp_addr[$];
  int            n_checks   = 0;
  int            n_err      = 0;
  int            pending    = 0;
  int            dones_seen = 0;
  int            taken      = 0;
  int            popped_n   = 0;
  int            rdy_mode   = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  exp_t          m_e;
  logic [AW-1:0] m_a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_busy"},  64'(bus.busy), 64'd0);
    chk({pfx, "_done"},  64'(bus.done), 64'd0);
    chk({pfx, "_en"},    64'(bus.bias_bram_en), 64'd0);
    chk({pfx, "_addr"},  64'(bus.bias_bram_addr), 64'd0);
    chk({pfx, "_valid"}, 64'(bus.bias_valid), 64'd0);
    chk({pfx, "_last"},  64'(bus.bias_last), 64'd0);
    chk({pfx, "_data"},  64'(bus.bias_data), 64'd0);
  endtask

  // Starts a request in the current cycle and records what it must produce.
  task automatic issue(input int base, input int cnt);
    exp_t e;
    int   a;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.count     = CW'(cnt);
    for (int i = 0; i < cnt; i++) begin
      a      = (base + i) % NADDR;
      e.data = mem[a];
      e.last = (i == cnt - 1);
      exp_q.push_back(e);
      exp_addr.push_back(AW'(a));
    end
    pending++;
    step();
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.count     = CW'($urandom);
  endtask

  task automatic wait_done(input string nm);
    int s = dones_seen;
    int n = 0;
    while (dones_seen == s && n < 4000) begin
      step();
      n++;
    end
    if (dones_seen == s) chk({nm, "_timeout"}, 64'd0, 64'd1);
    step();
  endtask

  // Downstream ready: 0 = always high, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    int ph = 0;
    bus.bias_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.bias_ready = (ph == 0) || (ph == 3);
        2:       bus.bias_ready = 1'($urandom_range(0, 1));
        default: bus.bias_ready = 1'b1;
      endcase
      ph = (ph + 1) % 4;
    end
  end

  // Monitor: read addresses, stream words, hold-while-stalled, occupancy, done
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      taken      = 0;
      popped_n   = 0;
    end else begin
      if (bus.bias_bram_en) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_en", 64'd1, 64'd0);
        end else begin
          m_a = exp_addr.pop_front();
          chk("bram_addr", 64'(bus.bias_bram_addr), 64'(m_a));
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.bias_valid), 64'd1);
        chk("hold_data", 64'(bus.bias_data), 64'(prev_data));
      end
      if (bus.bias_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          m_e = exp_q[0];
          chk("bias_data", 64'(bus.bias_data), 64'(m_e.data));
          chk("bias_last", 64'(bus.bias_last), 64'(m_e.last));
          if (bus.bias_ready) m_e = exp_q.pop_front();
        end
      end
      if (bus.bias_bram_rd_vld && !inj_vld) begin
        taken++;
        chk("fifo_bound", 64'(taken - popped_n <= int'(DEPTH)), 64'd1);
      end
      if (bus.bias_valid && bus.bias_ready) popped_n++;
      if (bus.done) begin
        chk("done_expected", 64'(pending > 0), 64'd1);
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        chk("words_left_at_done", 64'(exp_q.size()), 64'd0);
        if (pending > 0) pending--;
        dones_seen++;
      end
      prev_stall = bus.bias_valid & ~bus.bias_ready;
      prev_data  = bus.bias_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    for (int i = 0; i < int'(NADDR); i++) mem[i] = DW'(i + 100);

    // Reset state, during and just after reset
    repeat (3) step();
    @(negedge clk);
    chk_quiet("reset");
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    step();

    // Basic stream: cycle-exact timing for base 10, count 4
    rdy_mode = 0;
    issue(10, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("basic_en_c%0d", c), 64'(bus.bias_bram_en), 64'(c >= 1 && c <= 4));
      if (c <= 4) chk($sformatf("basic_addr_c%0d", c), 64'(bus.bias_bram_addr), 64'(10 + c - 1));
      chk($sformatf("basic_valid_c%0d", c), 64'(bus.bias_valid), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk($sformatf("basic_data_c%0d", c), 64'(bus.bias_data), 64'(107 + c));
      chk($sformatf("basic_last_c%0d", c), 64'(bus.bias_last), 64'(c == 6));
      chk($sformatf("basic_done_c%0d", c), 64'(bus.done), 64'(c == 7));
      chk($sformatf("basic_busy_c%0d", c), 64'(bus.busy), 64'(c <= 6));
      step();
    end

    // Backpressure with ready pattern 1,0,0,1
    for (int i = 0; i < int'(NADDR); i++) mem[i] = $urandom;
    rdy_mode = 1;
    issue(30, 6);
    wait_done("backpressure");

    // Address wrap 126,127,0,1
    rdy_mode = 0;
    issue(126, 4);
    wait_done("wrap");

    // Zero count: done next cycle, no reads, never busy
    issue(77, 0);
    @(negedge clk);
    chk("zero_done", 64'(bus.done), 64'd1);
    chk("zero_busy", 64'(bus.busy), 64'd0);
    repeat (3) step();

    // Start while busy is ignored
    rdy_mode = 2;
    issue(20, 6);
    step();
    bus.start     = 1'b1;
    bus.base_addr = AW'(50);
    bus.count     = CW'(3);
    step();
    bus.start = 1'b0;
    wait_done("start_busy");
    repeat (5) step();

    // Reset mid-operation, then a stray valid right after release
    rdy_mode = 0;
    issue(40, 8);
    step();
    step();
    rst = 1'b1;
    step();
    step();
    exp_q.delete();
    exp_addr.delete();
    pending = 0;
    rst = 1'b0;
    step();
    inj_vld = 1'b1;
    @(negedge clk);
    chk_quiet("after_mid_reset");
    step();
    inj_vld = 1'b0;
    @(negedge clk);
    chk("stray_vld_valid", 64'(bus.bias_valid), 64'd0);
    chk("stray_vld_data", 64'(bus.bias_data), 64'd0);
    step();
    rdy_mode = 2;
    issue(5, 2);
    wait_done("after_reset_req");

    // Randomized requests
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < int'(NADDR); i++) mem[i] = $urandom;
      rdy_mode = int'($urandom_range(0, 2));
      base     = int'($urandom_range(0, NADDR - 1));
      cnt      = (r == 3) ? int'(NADDR) : int'($urandom_range(0, 10));
      issue(base, cnt);
      wait_done($sformatf("rand%0d", r));
    end

    repeat (5) step();
    chk("final_words_left", 64'(exp_q.size()), 64'd0);
    chk("final_addrs_left", 64'(exp_addr.size()), 64'd0);
    chk("final_done_pending", 64'(pending), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
